// File: rtl/ram_bus_pkg.sv
// Shared definitions for the RAM arbiter: FSM state encoding, request kind,
// error flag bit positions and the data fill used when a read times out.
package ram_bus_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StWait  = 2'd2
    } state_e;

    typedef enum logic {
        KindRead  = 1'b0,
        KindWrite = 1'b1
    } kind_e;

    localparam int unsigned ErrP0Overrun = 0;
    localparam int unsigned ErrP1Overrun = 1;
    localparam int unsigned ErrTimeout   = 2;
    localparam int unsigned NumErrFlags  = 3;

    // Every bit of read data returned on a timed-out read takes this value.
    localparam logic TimeoutFillBit = 1'b1;

endpackage

// File: rtl/ram_arbiter_if.sv
// Pulse-request / pulse-ack RAM bus. The same bundle serves both requester
// ports and the RAM side of the arbiter.
//   master: drives addr, wdata, read_req, write_req; receives rdata and acks.
//   slave : receives the request; drives rdata, read_ack, write_ack.
interface ram_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              read_req;
    logic              write_req;
    logic [DATA_W-1:0] rdata;
    logic              read_ack;
    logic              write_ack;

    modport master (
        output addr, wdata, read_req, write_req,
        input  rdata, read_ack, write_ack
    );

    modport slave (
        input  addr, wdata, read_req, write_req,
        output rdata, read_ack, write_ack
    );
endinterface

// File: rtl/ram_port_latch.sv
// Pending-request latch for one requester. Captures a single-cycle request
// pulse with its address, data and kind, and holds it until the arbiter
// completes it.
//   clk_i, rst_ni          : clock, synchronous active-low reset
//   addr_i, wdata_i        : request address / write data
//   read_req_i, write_req_i: request pulses
//   clear_i                : transaction completed, drop the pending entry
//   pending_o, addr_o, wdata_o, kind_o : latched request
//   overrun_o              : request dropped or read+write collision this cycle
module ram_port_latch
    import ram_bus_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              read_req_i,
    input  logic              write_req_i,
    input  logic              clear_i,
    output logic              pending_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [DATA_W-1:0] wdata_o,
    output kind_e             kind_o,
    output logic              overrun_o
);

    logic              pending_q, pending_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    kind_e             kind_q, kind_d;
    logic              req;

    assign req = read_req_i | write_req_i;

    always_comb begin
        pending_d = pending_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        kind_d    = kind_q;
        // Dropped request, or ambiguous read+write (resolved as a write).
        overrun_o = req & (pending_q | (read_req_i & write_req_i));
        if (clear_i) begin
            pending_d = 1'b0;
        end
        if (req && !pending_q) begin
            pending_d = 1'b1;
            addr_d    = addr_i;
            wdata_d   = wdata_i;
            kind_d    = write_req_i ? KindWrite : KindRead;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pending_q <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            kind_q    <= KindRead;
        end else begin
            pending_q <= pending_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            kind_q    <= kind_d;
        end
    end

    assign pending_o = pending_q;
    assign addr_o    = addr_q;
    assign wdata_o   = wdata_q;
    assign kind_o    = kind_q;

endmodule

// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter in front of a single RAM port. Each requester
// pulses a read or write request; the request is latched, forwarded to the
// RAM one transaction at a time, and the RAM ack is returned (registered) to
// the owning port. A WAIT-state counter forces completion if the RAM never
// acks (TIMEOUT = 0 disables it).
//   clk_i, rst_ni  : clock, synchronous active-low reset
//   p0_io, p1_io   : requester buses (arbiter is the slave)
//   ram_io         : RAM bus (arbiter is the master)
//   grant_owner_o  : port owning the current or last transaction
//   busy_o         : transaction in ISSUE or WAIT
//   error_flags_o  : sticky {timeout, p1 overrun, p0 overrun}
//   error_clear_i  : clears error_flags_o
module ram_arbiter
    import ram_bus_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    ram_arbiter_if.slave           p0_io,
    ram_arbiter_if.slave           p1_io,
    ram_arbiter_if.master          ram_io,
    output logic                   grant_owner_o,
    output logic                   busy_o,
    output logic [NumErrFlags-1:0] error_flags_o,
    input  logic                   error_clear_i
);

    localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    // Counter value during the last WAIT cycle before a forced completion.
    localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT - 1);

    logic [1:0]        pend, ovr, clear;
    logic [ADDR_W-1:0] lat_addr  [2];
    logic [DATA_W-1:0] lat_wdata [2];
    kind_e             lat_kind  [2];

    state_e                  state_q, state_d;
    logic                    owner_q, owner_d;
    logic                    last_grant_q, last_grant_d;
    kind_e                   kind_q, kind_d;
    logic [ADDR_W-1:0]       ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0]       ram_wdata_q, ram_wdata_d;
    logic [CntW-1:0]         cnt_q, cnt_d;
    logic [DATA_W-1:0]       rdata_q [2];
    logic [DATA_W-1:0]       rdata_d [2];
    logic [1:0]              read_ack_q, read_ack_d;
    logic [1:0]              write_ack_q, write_ack_d;
    logic [NumErrFlags-1:0]  err_q, err_d;

    logic sel, done, timeout_evt, matched_ack;

    ram_port_latch #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_latch0 (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .addr_i      (p0_io.addr),
        .wdata_i     (p0_io.wdata),
        .read_req_i  (p0_io.read_req),
        .write_req_i (p0_io.write_req),
        .clear_i     (clear[0]),
        .pending_o   (pend[0]),
        .addr_o      (lat_addr[0]),
        .wdata_o     (lat_wdata[0]),
        .kind_o      (lat_kind[0]),
        .overrun_o   (ovr[0])
    );

    ram_port_latch #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_latch1 (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .addr_i      (p1_io.addr),
        .wdata_i     (p1_io.wdata),
        .read_req_i  (p1_io.read_req),
        .write_req_i (p1_io.write_req),
        .clear_i     (clear[1]),
        .pending_o   (pend[1]),
        .addr_o      (lat_addr[1]),
        .wdata_o     (lat_wdata[1]),
        .kind_o      (lat_kind[1]),
        .overrun_o   (ovr[1])
    );

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        kind_d       = kind_q;
        ram_addr_d   = ram_addr_q;
        ram_wdata_d  = ram_wdata_q;
        cnt_d        = cnt_q;
        rdata_d      = rdata_q;
        read_ack_d   = '0;
        write_ack_d  = '0;
        clear        = '0;
        sel          = 1'b0;
        done         = 1'b0;
        timeout_evt  = 1'b0;
        // Only the ack matching the request kind completes; the other is ignored.
        matched_ack  = (kind_q == KindWrite) ? ram_io.write_ack : ram_io.read_ack;

        unique case (state_q)
            StIdle: begin
                if (pend != 2'b00) begin
                    // On a tie, the port that did not win last time goes next.
                    sel         = (pend == 2'b11) ? ~last_grant_q : pend[1];
                    owner_d     = sel;
                    kind_d      = lat_kind[sel];
                    ram_addr_d  = lat_addr[sel];
                    ram_wdata_d = lat_wdata[sel];
                    state_d     = StIssue;
                end
            end
            StIssue: begin
                cnt_d = '0;
                if (matched_ack) begin
                    done = 1'b1;
                end else begin
                    state_d = StWait;
                end
            end
            StWait: begin
                cnt_d = cnt_q + CntW'(1);
                if (matched_ack) begin
                    done = 1'b1;
                end else if ((TIMEOUT != 0) && (cnt_q == TimeoutLast)) begin
                    done        = 1'b1;
                    timeout_evt = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (done) begin
            state_d        = StIdle;
            clear[owner_q] = 1'b1;
            last_grant_d   = owner_q;
            if (kind_q == KindWrite) begin
                write_ack_d[owner_q] = 1'b1;
            end else begin
                read_ack_d[owner_q] = 1'b1;
                rdata_d[owner_q]    = timeout_evt ? {DATA_W{TimeoutFillBit}} : ram_io.rdata;
            end
        end

        // A new error event in the clearing cycle keeps its flag set.
        err_d = error_clear_i ? '0 : err_q;
        if (ovr[0])      err_d[ErrP0Overrun] = 1'b1;
        if (ovr[1])      err_d[ErrP1Overrun] = 1'b1;
        if (timeout_evt) err_d[ErrTimeout]   = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            kind_q       <= KindRead;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
            cnt_q        <= '0;
            rdata_q[0]   <= '0;
            rdata_q[1]   <= '0;
            read_ack_q   <= '0;
            write_ack_q  <= '0;
            err_q        <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            kind_q       <= kind_d;
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
            cnt_q        <= cnt_d;
            rdata_q      <= rdata_d;
            read_ack_q   <= read_ack_d;
            write_ack_q  <= write_ack_d;
            err_q        <= err_d;
        end
    end

    assign ram_io.addr      = ram_addr_q;
    assign ram_io.wdata     = ram_wdata_q;
    assign ram_io.read_req  = (state_q == StIssue) && (kind_q == KindRead);
    assign ram_io.write_req = (state_q == StIssue) && (kind_q == KindWrite);

    assign p0_io.rdata     = rdata_q[0];
    assign p0_io.read_ack  = read_ack_q[0];
    assign p0_io.write_ack = write_ack_q[0];
    assign p1_io.rdata     = rdata_q[1];
    assign p1_io.read_ack  = read_ack_q[1];
    assign p1_io.write_ack = write_ack_q[1];

    assign grant_owner_o = owner_q;
    assign busy_o        = (state_q == StIssue) || (state_q == StWait);
    assign error_flags_o = err_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter (TIMEOUT = 4). Inputs change 1 time unit
// after the rising edge; outputs are sampled at the same point.
module tb_ram_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       grant;
    logic       busy;
    logic [2:0] flags;
    logic       err_clr;

    int checks = 0;
    int errors = 0;
    int unsigned rd_issues = 0;

    ram_arbiter_if #(.ADDR_W(32), .DATA_W(32)) p0_if ();
    ram_arbiter_if #(.ADDR_W(32), .DATA_W(32)) p1_if ();
    ram_arbiter_if #(.ADDR_W(32), .DATA_W(32)) ram_if ();

    ram_arbiter #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (4)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .p0_io         (p0_if),
        .p1_io         (p1_if),
        .ram_io        (ram_if),
        .grant_owner_o (grant),
        .busy_o        (busy),
        .error_flags_o (flags),
        .error_clear_i (err_clr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_if.read_req) rd_issues <= rd_issues + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        int n;
        int unsigned rd_base;
        rst_n = 1'b0;
        err_clr = 1'b0;
        p0_if.addr = '0; p0_if.wdata = '0; p0_if.read_req = 1'b0; p0_if.write_req = 1'b0;
        p1_if.addr = '0; p1_if.wdata = '0; p1_if.read_req = 1'b0; p1_if.write_req = 1'b0;
        ram_if.rdata = '0; ram_if.read_ack = 1'b0; ram_if.write_ack = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst_rdreq", 32'(ram_if.read_req), 32'd0);
        chk("rst_wrreq", 32'(ram_if.write_req), 32'd0);
        chk("rst_addr", ram_if.addr, 32'h0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_flags", 32'(flags), 32'd0);
        rst_n = 1'b1;
        tick();

        // Single read, RAM acks 3 cycles after readReq
        p0_if.addr = 32'h10; p0_if.read_req = 1'b1;
        tick();
        p0_if.read_req = 1'b0;
        chk("rd_not_yet", 32'(ram_if.read_req), 32'd0);
        tick();
        chk("rd_req", 32'(ram_if.read_req), 32'd1);
        chk("rd_addr", ram_if.addr, 32'h10);
        chk("rd_busy", 32'(busy), 32'd1);
        tick();
        chk("rd_req_once", 32'(ram_if.read_req), 32'd0);
        tick();
        tick();
        chk("rd_ack_early", 32'(p0_if.read_ack), 32'd0);
        ram_if.read_ack = 1'b1; ram_if.rdata = 32'h0badf00d;
        tick();
        ram_if.read_ack = 1'b0;
        chk("rd_ack", 32'(p0_if.read_ack), 32'd1);
        chk("rd_data", p0_if.rdata, 32'h0badf00d);
        chk("rd_p1_ack", 32'(p1_if.read_ack), 32'd0);
        chk("rd_p1_data", p1_if.rdata, 32'h0);
        chk("rd_idle", 32'(busy), 32'd0);
        tick();
        chk("rd_ack_pulse", 32'(p0_if.read_ack), 32'd0);
        chk("rd_data_hold", p0_if.rdata, 32'h0badf00d);

        // Simultaneous requests straight after reset
        do_reset();
        p0_if.addr = 32'h20; p0_if.read_req = 1'b1;
        p1_if.addr = 32'h40; p1_if.wdata = 32'h55; p1_if.write_req = 1'b1;
        tick();
        p0_if.read_req = 1'b0; p1_if.write_req = 1'b0;
        tick();
        chk("sim_p0_req", 32'(ram_if.read_req), 32'd1);
        chk("sim_p0_addr", ram_if.addr, 32'h20);
        chk("sim_p0_grant", 32'(grant), 32'd0);
        ram_if.read_ack = 1'b1; ram_if.rdata = 32'h11112222;
        tick();
        ram_if.read_ack = 1'b0;
        chk("sim_p0_ack", 32'(p0_if.read_ack), 32'd1);
        tick();
        chk("sim_p1_req", 32'(ram_if.write_req), 32'd1);
        chk("sim_p1_addr", ram_if.addr, 32'h40);
        chk("sim_p1_wdata", ram_if.wdata, 32'h55);
        chk("sim_p1_grant", 32'(grant), 32'd1);
        ram_if.write_ack = 1'b1;
        tick();
        ram_if.write_ack = 1'b0;
        chk("sim_p1_ack", 32'(p1_if.write_ack), 32'd1);

        // Fairness under load: both ports re-request after each ack
        do_reset();
        p0_if.addr = 32'h100; p0_if.read_req = 1'b1;
        p1_if.addr = 32'h200; p1_if.read_req = 1'b1;
        tick();
        p0_if.read_req = 1'b0; p1_if.read_req = 1'b0;
        for (int i = 0; i < 6; i++) begin
            n = 0;
            while (!ram_if.read_req && n < 10) begin
                tick();
                n++;
            end
            chk("fair_issue", 32'(ram_if.read_req), 32'd1);
            chk("fair_grant", 32'(grant), 32'(i % 2));
            chk("fair_addr", ram_if.addr, (i % 2 == 1) ? 32'h200 : 32'h100);
            ram_if.read_ack = 1'b1; ram_if.rdata = 32'(i);
            tick();
            ram_if.read_ack = 1'b0;
            chk("fair_ack", 32'((i % 2 == 1) ? p1_if.read_ack : p0_if.read_ack), 32'd1);
            if (i < 4) begin
                if (i % 2 == 1) p1_if.read_req = 1'b1;
                else            p0_if.read_req = 1'b1;
                tick();
                p0_if.read_req = 1'b0; p1_if.read_req = 1'b0;
            end
        end
        chk("fair_flags", 32'(flags), 32'd0);

        // Overrun on port 1, then clear
        rd_base = rd_issues;
        p1_if.addr = 32'h60; p1_if.read_req = 1'b1;
        tick();
        tick();
        p1_if.read_req = 1'b0;
        chk("ovr_flag", 32'(flags), 32'h2);
        chk("ovr_req", 32'(ram_if.read_req), 32'd1);
        chk("ovr_addr", ram_if.addr, 32'h60);
        ram_if.read_ack = 1'b1; ram_if.rdata = 32'h77;
        tick();
        ram_if.read_ack = 1'b0;
        chk("ovr_ack", 32'(p1_if.read_ack), 32'd1);
        tick();
        tick();
        tick();
        chk("ovr_one_read", rd_issues - rd_base, 32'd1);
        chk("ovr_idle", 32'(busy), 32'd0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("ovr_clear", 32'(flags), 32'd0);

        // Timeout: RAM never acks a port 0 read
        p0_if.addr = 32'h80; p0_if.read_req = 1'b1;
        tick();
        p0_if.read_req = 1'b0;
        tick();
        chk("to_req", 32'(ram_if.read_req), 32'd1);
        tick(); tick(); tick(); tick();
        chk("to_no_ack_yet", 32'(p0_if.read_ack), 32'd0);
        chk("to_busy", 32'(busy), 32'd1);
        tick();
        chk("to_ack", 32'(p0_if.read_ack), 32'd1);
        chk("to_fill", p0_if.rdata, 32'hffffffff);
        chk("to_flag", 32'(flags), 32'h4);
        ram_if.read_ack = 1'b1;
        tick();
        ram_if.read_ack = 1'b0;
        chk("to_late_ack", 32'(p0_if.read_ack), 32'd0);
        tick();
        chk("to_late_ack2", 32'(p0_if.read_ack), 32'd0);
        chk("to_idle", 32'(busy), 32'd0);

        // Reset during an outstanding write
        p0_if.addr = 32'h90; p0_if.wdata = 32'hab; p0_if.write_req = 1'b1;
        tick();
        p0_if.write_req = 1'b0;
        tick();
        chk("mr_wrreq", 32'(ram_if.write_req), 32'd1);
        tick();
        do_reset();
        chk("mr_addr", ram_if.addr, 32'h0);
        chk("mr_wdata", ram_if.wdata, 32'h0);
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_grant", 32'(grant), 32'd0);
        chk("mr_flags", 32'(flags), 32'd0);
        chk("mr_p0_data", p0_if.rdata, 32'h0);
        chk("mr_p0_wack", 32'(p0_if.write_ack), 32'd0);
        ram_if.write_ack = 1'b1;
        tick();
        ram_if.write_ack = 1'b0;
        chk("mr_late_wack", 32'(p0_if.write_ack), 32'd0);
        chk("mr_late_busy", 32'(busy), 32'd0);
        p1_if.addr = 32'ha0; p1_if.read_req = 1'b1;
        tick();
        p1_if.read_req = 1'b0;
        tick();
        chk("mr_next_req", 32'(ram_if.read_req), 32'd1);
        chk("mr_next_addr", ram_if.addr, 32'ha0);
        chk("mr_next_grant", 32'(grant), 32'd1);
        ram_if.read_ack = 1'b1; ram_if.rdata = 32'h1234;
        tick();
        ram_if.read_ack = 1'b0;
        chk("mr_next_ack", 32'(p1_if.read_ack), 32'd1);
        chk("mr_next_data", p1_if.rdata, 32'h1234);

        // Read+write together resolves as write; non-matching ack ignored
        p0_if.addr = 32'hb0; p0_if.wdata = 32'hcd;
        p0_if.read_req = 1'b1; p0_if.write_req = 1'b1;
        tick();
        p0_if.read_req = 1'b0; p0_if.write_req = 1'b0;
        chk("rw_flag", 32'(flags), 32'h1);
        tick();
        chk("rw_wrreq", 32'(ram_if.write_req), 32'd1);
        chk("rw_rdreq", 32'(ram_if.read_req), 32'd0);
        ram_if.read_ack = 1'b1;
        tick();
        ram_if.read_ack = 1'b0;
        chk("rw_wrong_ack_w", 32'(p0_if.write_ack), 32'd0);
        chk("rw_wrong_ack_r", 32'(p0_if.read_ack), 32'd0);
        chk("rw_still_busy", 32'(busy), 32'd1);
        ram_if.write_ack = 1'b1;
        tick();
        ram_if.write_ack = 1'b0;
        chk("rw_wack", 32'(p0_if.write_ack), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single RAM port between two requesters: port 0 is the core's ramAddress/readReq/writeReq interface, and port 1 is a loader/DMA master.
- Each requester sees the same pulse-request / pulse-ack protocol the core already uses.
- Sits between the core/loader and the RAM model. It latches single-cycle requests, arbitrates round-robin, forwards one transaction at a time, and returns acks and read data to the owner.
- Includes an ack timeout so a lost ack never hangs the core.

Parameters:
ADDR_W, 32, address width of all ports
DATA_W, 32, data width of all ports
TIMEOUT, 255, WAIT cycles before forced completion; 0 disables the timeout

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-low reset
p0Address  input  ADDR_W  port 0 request address
p0DataOut  input  DATA_W  port 0 write data
p0ReadReq  input  1  port 0 read request pulse
p0WriteReq  input  1  port 0 write request pulse
p0DataIn  output  DATA_W  port 0 read data
p0ReadAck  output  1  port 0 read done pulse
p0WriteAck  output  1  port 0 write done pulse
p1Address, p1DataOut, p1ReadReq, p1WriteReq, p1DataIn, p1ReadAck, p1WriteAck  (same as port 0, for port 1)
ramAddress  output  ADDR_W  RAM address
ramOut  output  DATA_W  RAM write data
readReq  output  1  RAM read request pulse
writeReq  output  1  RAM write request pulse
ramIn  input  DATA_W  RAM read data
readAck  input  1  RAM read acknowledge
writeAck  input  1  RAM write acknowledge
grantOwner  output  1  port that owns the current or last transaction
busy  output  1  high while in ISSUE or WAIT
errorFlags  output  3  sticky flags: [0] p0 overrun, [1] p1 overrun, [2] timeout
errorClear  input  1  clears errorFlags

Behaviour:
- Reset (reset==0 at a clk edge): every output is 0; pending latches cleared; state IDLE; lastGrant=1, so port 0 wins the first tie; timeout counter 0.
- Capture: a request pulse sampled high is latched with its address, data and kind, provided that port has nothing pending.
  - Read and write high together on one port: latched as a write; that port's overrun flag is set.
  - Request while that port is already pending: the request is dropped; that port's overrun flag is set.
- States:
  - IDLE:
    - No pending request: stay.
    - Otherwise choose a port. If both are pending, choose the one other than lastGrant.
    - Register ramAddress, ramOut and grantOwner; go to ISSUE.
  - ISSUE: drive readReq or writeReq high for exactly this one cycle; clear the timeout counter; go to WAIT.
  - WAIT:
    - Request lines are 0. The counter increments each cycle.
    - The matching ack (readAck for a read, writeAck for a write) sampled high completes the transaction.
    - A non-matching ack is ignored.
    - An ack sampled during the ISSUE cycle also counts, taking effect at that edge.
- Completion, registered (one cycle after the ack is sampled):
  - The owner's pXReadAck or pXWriteAck pulses for one cycle.
  - On a read, pXDataIn<=ramIn in the same edge. pXDataIn holds its value until that port's next read completes.
  - Clear the owner's pending latch; lastGrant<=owner; go to IDLE.
- Latency:
  - Request sampled at edge E: the RAM request is visible in cycle E+2.
  - RAM ack sampled at edge A: the requester ack is visible in cycle A+1.
  - Minimum round trip is 4 cycles.
- Timeout:
  - When the counter reaches TIMEOUT with no ack, complete as above with pXDataIn=all-ones for reads, and set errorFlags[2].
  - A late RAM ack arriving in IDLE is ignored.
- Capture runs in every state, so the other port can queue while a transaction is in flight.
  - It is served immediately after the current transaction, giving strict alternation under load.
- errorClear clears all flags. A new error event in the same cycle wins: that flag stays set.
- Reset mid-transaction aborts it without any ack to the requester. An outstanding RAM ack arriving after reset is ignored.
- busy=1 in ISSUE and WAIT.

Decomposition:
- Package ram_bus_pkg holds:
  - the state encoding IDLE/ISSUE/WAIT;
  - the errorFlags bit indices;
  - the read-timeout fill value (all ones);
  - the request kind encoding (read/write).
- Sub-module ram_port_latch: a per-requester pending latch holding address, data and kind, with overrun detection. It is instantiated twice.

Test Plan:
- Single read: p0ReadReq pulse with p0Address=0x10; RAM acks 3 cycles after readReq with ramIn=0x0badf00d -> readReq in cycle E+2; p0ReadAck pulse; p0DataIn=0x0badf00d; port 1 outputs unchanged.
- Simultaneous requests: p0 reads 0x20 and p1 writes 0x55 to 0x40 in the same cycle, right after reset -> port 0 served first; then writeReq with ramAddress=0x40 and ramOut=0x55; p1WriteAck follows; grantOwner goes 0 then 1.
- Fairness under load: both ports re-request immediately after each ack, for 6 transactions -> grants alternate 0,1,0,1,0,1; errorFlags=0.
- Overrun: second p1ReadReq while p1 is pending -> errorFlags[1]=1; only one RAM read is issued. Then errorClear -> errorFlags=0.
- Timeout with TIMEOUT=4: RAM never acks a p0 read -> p0ReadAck 4 WAIT cycles after ISSUE; p0DataIn=0xffffffff; errorFlags[2]=1. A late readAck afterwards produces no extra ack.
- Reset mid-WAIT: reset=0 for 1 cycle during an outstanding write -> all outputs 0; no p0WriteAck; the next request proceeds normally.
